// File: rtl/dct_pkg.sv
// Shared constants and types for the 16x16 2-D DCT datapath.
package dct_pkg;

    localparam int DCT_N       = 16;
    localparam int DCT_COEF_BW = 11;

    typedef logic signed [DCT_COEF_BW-1:0] coef_t;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_e;

endpackage

// File: rtl/dct_tp_bank.sv
// One N x N coefficient store: written a whole row at a time, read a whole column at a time.
module dct_tp_bank
    import dct_pkg::*;
#(
    parameter int BW = DCT_COEF_BW,
    parameter int N  = DCT_N
) (
    input  logic            clk,
    input  logic            we,
    input  logic [3:0]      wr_row,
    input  logic [N*BW-1:0] wr_data,
    input  logic [3:0]      rd_col,
    output logic [N*BW-1:0] rd_data
);

    logic [BW-1:0] mem_reg [N][N];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < N; k++) begin
                mem_reg[wr_row][k] <= wr_data[(N-1-k)*BW +: BW];
            end
        end
    end

    // Column read is a plain mux; the top registers the selected column.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rd
            assign rd_data[(N-1-gi)*BW +: BW] = mem_reg[gi][rd_col];
        end
    endgenerate

endmodule

// File: rtl/dct_transpose_buffer.sv
// Row-in / column-out transpose buffer between the row and column DCT passes.
// DCT_TRANSPOSE_PINGPONG_EN selects two banks (fill while draining); default is one bank.
module dct_transpose_buffer
    import dct_pkg::*;
#(
    parameter int BW = DCT_COEF_BW,
    parameter int N  = DCT_N
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N*BW-1:0] row_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N*BW-1:0] col_out,
    output logic [3:0]      col_idx,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready
);

`ifdef DCT_TRANSPOSE_PINGPONG_EN
    localparam int   NUM_BANKS = 2;
    localparam logic PINGPONG  = 1'b1;
`else
    localparam int   NUM_BANKS = 1;
    localparam logic PINGPONG  = 1'b0;
`endif
    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    bank_state_e     bank_state_reg [2];
    logic [N*BW-1:0] bank_col       [2];
    logic [BW-1:0]   in_coef        [N];

    logic            wr_bank_reg;
    logic [3:0]      wr_row_reg;
    logic            rd_bank_reg;
    logic [3:0]      rd_col_reg;
    logic            drained_reg;

    logic [N*BW-1:0] col_out_reg;
    logic [3:0]      col_idx_reg;
    logic            out_last_reg;
    logic            out_valid_reg;

    logic            wr_accept;
    logic            wr_complete;
    logic            release_bank;
    logic            can_advance;
    logic            src_bank;
    logic            bypass;
    logic            src_full;
    logic            load;
    logic [N*BW-1:0] col_data;

    assign in_ready     = !rstn && (bank_state_reg[wr_bank_reg] == BANK_FREE);
    assign wr_accept    = in_valid && in_ready;
    assign wr_complete  = wr_accept && (wr_row_reg == LAST_IDX);
    assign release_bank = out_valid_reg && out_ready && out_last_reg;
    assign can_advance  = !out_valid_reg || out_ready;

    // Once all columns of the current bank are loaded, the next load comes from
    // the other bank, and only on the very cycle the last column is taken.
    assign src_bank = drained_reg ? (rd_bank_reg ^ PINGPONG) : rd_bank_reg;
    // The bank's final row is still being written: take row 15 from row_in.
    assign bypass   = wr_complete && (wr_bank_reg == src_bank);
    assign src_full = (bank_state_reg[src_bank] == BANK_FULL) || bypass;
    assign load     = can_advance && src_full && (!drained_reg || (release_bank && PINGPONG));

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_in_coef
            assign in_coef[gi] = row_in[(N-1-gi)*BW +: BW];
        end

        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            if (gi < NUM_BANKS) begin : g_inst
                dct_tp_bank #(
                    .BW(BW),
                    .N (N)
                ) u_bank (
                    .clk    (clk),
                    .we     (wr_accept && (wr_bank_reg == 1'(gi))),
                    .wr_row (wr_row_reg),
                    .wr_data(row_in),
                    .rd_col (rd_col_reg),
                    .rd_data(bank_col[gi])
                );
            end else begin : g_none
                assign bank_col[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        col_data = bank_col[src_bank];
        if (bypass) begin
            col_data[BW-1:0] = in_coef[rd_col_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            bank_state_reg[0] <= BANK_FREE;
            bank_state_reg[1] <= BANK_FREE;
            wr_bank_reg       <= 1'b0;
            wr_row_reg        <= 4'd0;
            rd_bank_reg       <= 1'b0;
            rd_col_reg        <= 4'd0;
            drained_reg       <= 1'b0;
            col_out_reg       <= '0;
            col_idx_reg       <= 4'd0;
            out_last_reg      <= 1'b0;
            out_valid_reg     <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_row_reg <= wr_row_reg + 4'd1;
                if (wr_complete) begin
                    bank_state_reg[wr_bank_reg] <= BANK_FULL;
                    wr_bank_reg                 <= wr_bank_reg ^ PINGPONG;
                end
            end

            if (release_bank) begin
                bank_state_reg[rd_bank_reg] <= BANK_FREE;
                rd_bank_reg                 <= rd_bank_reg ^ PINGPONG;
                drained_reg                 <= 1'b0;
            end

            // rd_col wraps 15 -> 0, so the next bank always starts at column 0.
            if (load) begin
                col_out_reg   <= col_data;
                col_idx_reg   <= rd_col_reg;
                out_last_reg  <= (rd_col_reg == LAST_IDX);
                out_valid_reg <= 1'b1;
                rd_col_reg    <= rd_col_reg + 4'd1;
                drained_reg   <= (rd_col_reg == LAST_IDX);
            end else if (can_advance) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign col_out   = col_out_reg;
    assign col_idx   = col_idx_reg;
    assign out_last  = out_last_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Self-checking bench for dct_transpose_buffer: queue-based block/column model plus directed literals.
`timescale 1ns/1ps
module tb_dct_transpose_buffer;

    localparam int N  = 16;
    localparam int BW = 11;
    localparam int W  = N * BW;
`ifdef DCT_TRANSPOSE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [W-1:0] row_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] col_out;
    logic [3:0]   col_idx;
    logic         out_last;
    logic         out_valid;
    logic         out_ready = 1'b1;

    dct_transpose_buffer #(.BW(BW), .N(N)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .row_in   (row_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .col_out  (col_out),
        .col_idx  (col_idx),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [W-1:0] d;
        logic [3:0]   idx;
        logic         last;
    } col_t;

    col_t         pend[$];
    col_t         m_cur = '0;
    logic         m_ov = 1'b0;
    logic [W-1:0] blk [N];
    int           wrow = 0;
    int           full_cnt = 0;
    logic         acc, rel, adv;

    function automatic void push_block();
        col_t c;
        for (int k = 0; k < N; k++) begin
            c.d = '0;
            for (int r = 0; r < N; r++) c.d[(N-1-r)*BW +: BW] = blk[r][(N-1-k)*BW +: BW];
            c.idx  = 4'(k);
            c.last = (k == N - 1);
            pend.push_back(c);
        end
    endfunction

    always begin
        @(posedge clk);
        if (rstn) begin
            pend.delete();
            wrow = 0;
            full_cnt = 0;
            m_ov = 1'b0;
            m_cur = '0;
        end else begin
            acc = in_valid && (full_cnt < NB);
            rel = m_ov && out_ready && m_cur.last;
            adv = !m_ov || out_ready;
            if (acc) begin
                blk[wrow] = row_in;
                wrow++;
                if (wrow == N) begin
                    wrow = 0;
                    full_cnt++;
                    push_block();
                end
            end
            if (rel) full_cnt--;
            if (adv) begin
                if (pend.size() > 0) begin
                    m_cur = pend.pop_front();
                    m_ov = 1'b1;
                end else begin
                    m_ov = 1'b0;
                end
            end
        end
        #1;
        chk("in_ready", W'(in_ready), W'(!rstn && (full_cnt < NB)));
        chk("out_valid", W'(out_valid), W'(m_ov));
        if (m_ov) begin
            chk("col_out", col_out, m_cur.d);
            chk("col_idx", W'(col_idx), W'(m_cur.idx));
            chk("out_last", W'(out_last), W'(m_cur.last));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [W-1:0] make_row(input int mode, input int r, input int b);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       v[(N-1-k)*BW +: BW] = BW'(16 * r + k + b);
                1:       v[(N-1-k)*BW +: BW] = (r == 0) ? 11'h400 : 11'h3FF;
                default: v[(N-1-k)*BW +: BW] = BW'($urandom);
            endcase
        end
        return v;
    endfunction

    function automatic logic [BW-1:0] get_el(input logic [W-1:0] v, input int r);
        return v[(N-1-r)*BW +: BW];
    endfunction

    // Holds in_valid high until nrows rows are accepted; the last accept happens
    // on the clock edge after this task returns.
    task automatic feed(input int mode, input int b, input int nrows, output int low);
        int r;
        int budget;
        r = 0;
        budget = 0;
        low = 0;
        while (r < nrows && budget < 400) begin
            @(negedge clk);
            in_valid = 1'b1;
            row_in = make_row(mode, r, b);
            if (in_ready) r++;
            else low++;
            budget++;
        end
        chk("feed_rows", W'(r), W'(nrows));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((m_ov || pend.size() > 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", W'(t < 400), W'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int low;
        int total;
        logic [W-1:0] v;

        rstn = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_col_out", col_out, '0);
        chk("rst_col_idx", W'(col_idx), W'(0));
        chk("rst_out_last", W'(out_last), W'(0));

        // Single block, ramp pattern
        out_ready = 1'b1;
        feed(0, 0, 16, low);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_valid", W'(out_valid), W'(1));
        chk("lat_idx", W'(col_idx), W'(0));
        chk("c0_r15", W'(get_el(col_out, 15)), W'(240));
        @(negedge clk);
        chk("c1_idx", W'(col_idx), W'(1));
        chk("c1_r0", W'(get_el(col_out, 0)), W'(1));
        wait_idle();

        // Negative values, bit-exact
        feed(1, 0, 16, low);
        @(negedge clk);
        in_valid = 1'b0;
        v = {11'h400, {15{11'h3FF}}};
        chk("neg_col0", col_out, v);
        wait_idle();

        // Back-to-back blocks
        total = 0;
        for (int b = 0; b < 3; b++) begin
            feed(0, b, 16, low);
            total += low;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_ready_low", W'(total), W'((NB == 2) ? 0 : 32));
        wait_idle();

        // Backpressure
        out_ready = 1'b0;
        feed(0, 0, 16, low);
        if (NB == 2) feed(0, 1, 16, low);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_in_ready", W'(in_ready), W'(0));
        chk("bp_valid", W'(out_valid), W'(1));
        chk("bp_idx", W'(col_idx), W'(0));
        chk("bp_r3", W'(get_el(col_out, 3)), W'(48));
        repeat (5) @(negedge clk);
        chk("bp_hold_idx", W'(col_idx), W'(0));
        chk("bp_hold_r3", W'(get_el(col_out, 3)), W'(48));
        out_ready = 1'b1;
        wait_idle();

        // Reset mid-operation
        feed(0, 0, 16, low);
        feed(0, 1, 7, low);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", W'(out_valid), W'(0));
        chk("mid_rst_ready", W'(in_ready), W'(1));
        feed(0, 5, 16, low);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fresh_idx", W'(col_idx), W'(0));
        chk("fresh_r2", W'(get_el(col_out, 2)), W'(37));
        wait_idle();

        // Randomized traffic
        repeat (1500) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            row_in    = make_row(2, 0, 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
